// File: rtl/rm_lane_arbiter.sv
// ---------------------------------------------------------------------------
// rm_lane_arbiter
//
// Purpose:
//   Shares a pool of runtime-monitor lanes among several decode-side event
//   sources in the ID stage. One requester is granted per cycle, chosen
//   round-robin. The grant always takes the lowest-indexed free lane. Each
//   lane is then tracked through speculative allocation, commit and release.
//   A pipeline flush reclaims speculative lanes. A per-lane watchdog
//   reclaims lanes that are never released.
//
// Parameters:
//   NUM_LANES  number of monitor lanes (>= 2)
//   NUM_REQ    number of requesters (>= 1)
//   TIMEOUT    cycles a lane may stay allocated before forced reclaim;
//              0 disables the watchdog
//
// Ports:
//   clk_i        in   1          clock
//   rst_i        in   1          synchronous active-high reset
//   flush_i      in   1          pipeline flush, reclaims speculative lanes
//   req_i        in   NUM_REQ    per-requester lane request (level)
//   gnt_o        out  NUM_REQ    one-hot grant, combinational
//   gnt_valid_o  out  1          OR of gnt_o
//   gnt_lane_o   out  LANE_W     lane granted this cycle (0 when no grant)
//   commit_i     in   NUM_LANES  mark lane committed (non-speculative)
//   release_i    in   NUM_LANES  lane finished, free it
//   lane_busy_o  out  NUM_LANES  lane not FREE (registered state)
//   timeout_o    out  NUM_LANES  one-cycle pulse on watchdog reclaim
//   full_o       out  1          no lane FREE (registered state)
// ---------------------------------------------------------------------------
module rm_lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NUM_REQ-1:0]           req_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic                         gnt_valid_o,
  output logic [$clog2(NUM_LANES)-1:0] gnt_lane_o,
  input  logic [NUM_LANES-1:0]         commit_i,
  input  logic [NUM_LANES-1:0]         release_i,
  output logic [NUM_LANES-1:0]         lane_busy_o,
  output logic [NUM_LANES-1:0]         timeout_o,
  output logic                         full_o
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Counter value at which an allocated lane is reclaimed. TIMEOUT-1 always
  // fits in CNT_W bits, so the counter never needs to go past this value.
  localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    LANE_FREE,
    LANE_ALLOC,
    LANE_COMMITTED
  } lane_state_e;

  lane_state_e          lane_state_q [NUM_LANES];
  logic [CNT_W-1:0]     wd_cnt_q     [NUM_LANES];
  logic [NUM_LANES-1:0] timeout_q;
  logic [REQ_W-1:0]     rr_ptr_q;

  logic [NUM_LANES-1:0] lane_free;
  logic [NUM_LANES-1:0] lane_expire;
  logic                 all_busy;
  logic                 free_found;
  logic [LANE_W-1:0]    free_lane;
  logic                 win_found;
  logic [REQ_W-1:0]     winner;
  logic                 gnt_valid;

  // Per-lane status decoded from the registered state. A lane expires when
  // its counter has reached TIMEOUT-1 while it is still allocated.
  always_comb begin
    lane_free   = '0;
    lane_expire = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_free[l] = (lane_state_q[l] == LANE_FREE);
      if (TIMEOUT > 0) begin
        lane_expire[l] = !lane_free[l] && (wd_cnt_q[l] == CNT_MAX);
      end
    end
  end

  assign all_busy = ~|lane_free;

  // Lowest-indexed free lane. Uses registered state only, so a lane released
  // this cycle is not offered until the next cycle.
  always_comb begin
    free_found = 1'b0;
    free_lane  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (!free_found && lane_free[l]) begin
        free_found = 1'b1;
        free_lane  = LANE_W'(l);
      end
    end
  end

  // Round-robin winner. The first pass looks at requesters at or above the
  // pointer; if none are requesting, the second pass takes the lowest index,
  // which is the wrap-around continuation of the same scan.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!win_found && req_i[r] && (r >= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        winner    = REQ_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!win_found && req_i[r]) begin
        win_found = 1'b1;
        winner    = REQ_W'(r);
      end
    end
  end

  // Grants are held off during a flush and while every lane is in use.
  assign gnt_valid = win_found && !flush_i && !all_busy;

  always_comb begin
    gnt_o = '0;
    if (gnt_valid) begin
      gnt_o = NUM_REQ'(1) << winner;
    end
  end

  assign gnt_valid_o = gnt_valid;
  assign gnt_lane_o  = gnt_valid ? free_lane : '0;
  assign lane_busy_o = ~lane_free;
  assign timeout_o   = timeout_q;
  assign full_o      = all_busy;

  // Lane state machine, watchdog counters and round-robin pointer.
  // Event priority on an occupied lane: release, then flush (speculative
  // lanes only), then watchdog, then commit. Only the watchdog path raises
  // the timeout pulse, so a release or flush in the expiry cycle is silent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_state_q[l] <= LANE_FREE;
        wd_cnt_q[l]     <= '0;
      end
      timeout_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        timeout_q[l] <= 1'b0;
        if (lane_free[l]) begin
          if (gnt_valid && (free_lane == LANE_W'(l))) begin
            lane_state_q[l] <= LANE_ALLOC;
            wd_cnt_q[l]     <= '0;
          end
        end else if (release_i[l]) begin
          lane_state_q[l] <= LANE_FREE;
          wd_cnt_q[l]     <= '0;
        end else if (flush_i && (lane_state_q[l] == LANE_ALLOC)) begin
          lane_state_q[l] <= LANE_FREE;
          wd_cnt_q[l]     <= '0;
        end else if (lane_expire[l]) begin
          lane_state_q[l] <= LANE_FREE;
          wd_cnt_q[l]     <= '0;
          timeout_q[l]    <= 1'b1;
        end else begin
          if (commit_i[l] && (lane_state_q[l] == LANE_ALLOC)) begin
            lane_state_q[l] <= LANE_COMMITTED;
          end
          // Saturate rather than wrap; with the watchdog disabled the
          // counter stays at zero.
          if ((TIMEOUT > 0) && (wd_cnt_q[l] != CNT_MAX)) begin
            wd_cnt_q[l] <= wd_cnt_q[l] + CNT_W'(1);
          end
        end
      end

      if (gnt_valid) begin
        rr_ptr_q <= (winner == REQ_LAST) ? '0 : winner + REQ_W'(1);
      end
    end
  end

  // A granted lane must be free in the registered state.
  always_ff @(posedge clk_i) begin
    if (!rst_i && gnt_valid) begin
      assert (lane_free[free_lane]);
    end
  end

endmodule

// File: tb/tb_rm_lane_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rm_lane_arbiter
//
// Directed testbench for rm_lane_arbiter with NUM_LANES=4, NUM_REQ=2 and
// TIMEOUT=8. Inputs are driven just after the falling edge and outputs are
// sampled 1ns later, well away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_rm_lane_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic [1:0] req_i = '0;
  logic [1:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_lane_o;
  logic [3:0] commit_i = '0;
  logic [3:0] release_i = '0;
  logic [3:0] lane_busy_o;
  logic [3:0] timeout_o;
  logic       full_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  rm_lane_arbiter #(
    .NUM_LANES(4),
    .NUM_REQ  (2),
    .TIMEOUT  (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_lane_o (gnt_lane_o),
    .commit_i   (commit_i),
    .release_i  (release_i),
    .lane_busy_o(lane_busy_o),
    .timeout_o  (timeout_o),
    .full_o     (full_o)
  );

  // Advance to the next falling edge (one rising edge in between).
  task automatic tick();
    @(negedge clk_i);
  endtask

  // Clear all inputs and apply one reset edge; returns at the falling edge
  // of the first cycle after reset.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    req_i     = '0;
    commit_i  = '0;
    release_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL reset_busy: got %b want 0000", lane_busy_o);
    end
    vec_cnt++;
    if (timeout_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL reset_timeout: got %b want 0000", timeout_o);
    end
    vec_cnt++;
    if (full_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL reset_full: got %b want 0", full_o);
    end
    vec_cnt++;
    if (gnt_valid_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL reset_gnt_valid: got %b want 0", gnt_valid_o);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_busy;
    logic [1:0] exp_lane;
    do_reset();
    req_i = 2'b01;
    for (int c = 0; c < 4; c++) begin
      exp_busy = 4'((1 << c) - 1);
      exp_lane = 2'(c);
      #1;
      vec_cnt++;
      if (gnt_o !== 2'b01 || gnt_valid_o !== 1'b1) begin
        err_cnt++;
        $display("[TB] FAIL fill_gnt c%0d: got %b/%b want 01/1", c, gnt_o, gnt_valid_o);
      end
      vec_cnt++;
      if (gnt_lane_o !== exp_lane) begin
        err_cnt++;
        $display("[TB] FAIL fill_lane c%0d: got %0d want %0d", c, gnt_lane_o, exp_lane);
      end
      vec_cnt++;
      if (lane_busy_o !== exp_busy) begin
        err_cnt++;
        $display("[TB] FAIL fill_busy c%0d: got %b want %b", c, lane_busy_o, exp_busy);
      end
      tick();
    end
    #1;
    vec_cnt++;
    if (full_o !== 1'b1 || lane_busy_o !== 4'b1111) begin
      err_cnt++;
      $display("[TB] FAIL fill_full: got %b/%b want 1/1111", full_o, lane_busy_o);
    end
    vec_cnt++;
    if (gnt_o !== 2'b00 || gnt_valid_o !== 1'b0 || gnt_lane_o !== 2'd0) begin
      err_cnt++;
      $display("[TB] FAIL fill_nogrant: got %b/%b/%0d want 00/0/0", gnt_o, gnt_valid_o, gnt_lane_o);
    end
    req_i = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] exp_lane;
    do_reset();
    req_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_lane = 2'(c);
      #1;
      vec_cnt++;
      if (gnt_o !== exp_gnt) begin
        err_cnt++;
        $display("[TB] FAIL rr_gnt c%0d: got %b want %b", c, gnt_o, exp_gnt);
      end
      vec_cnt++;
      if (gnt_lane_o !== exp_lane) begin
        err_cnt++;
        $display("[TB] FAIL rr_lane c%0d: got %0d want %0d", c, gnt_lane_o, exp_lane);
      end
      tick();
    end
    req_i = 2'b00;
  endtask

  task automatic test_flush();
    do_reset();
    req_i = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    req_i    = 2'b00;
    commit_i = 4'b0011;
    #1;
    vec_cnt++;
    if (full_o !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL flush_prefull: got %b want 1", full_o);
    end
    tick();
    commit_i = 4'b0000;
    flush_i  = 1'b1;
    req_i    = 2'b01;
    #1;
    vec_cnt++;
    if (gnt_o !== 2'b00 || gnt_valid_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL flush_nogrant: got %b/%b want 00/0", gnt_o, gnt_valid_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0011 || full_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL flush_busy: got %b/%b want 0011/0", lane_busy_o, full_o);
    end
    vec_cnt++;
    if (gnt_lane_o !== 2'd2 || gnt_o !== 2'b01) begin
      err_cnt++;
      $display("[TB] FAIL flush_regrant: got lane %0d gnt %b want lane 2 gnt 01", gnt_lane_o, gnt_o);
    end
    tick();
    req_i     = 2'b00;
    release_i = 4'b0001;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0111) begin
      err_cnt++;
      $display("[TB] FAIL flush_after_regrant: got %b want 0111", lane_busy_o);
    end
    tick();
    release_i = 4'b0000;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0110) begin
      err_cnt++;
      $display("[TB] FAIL committed_release: got %b want 0110", lane_busy_o);
    end
  endtask

  task automatic test_collision();
    do_reset();
    req_i = 2'b01;
    for (int c = 0; c < 3; c++) tick();
    commit_i  = 4'b0100;
    release_i = 4'b0100;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0111) begin
      err_cnt++;
      $display("[TB] FAIL coll_busy_before: got %b want 0111", lane_busy_o);
    end
    vec_cnt++;
    if (gnt_lane_o !== 2'd3) begin
      err_cnt++;
      $display("[TB] FAIL coll_no_bypass: got lane %0d want 3", gnt_lane_o);
    end
    tick();
    commit_i  = 4'b0000;
    release_i = 4'b0000;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b1011) begin
      err_cnt++;
      $display("[TB] FAIL coll_busy_after: got %b want 1011", lane_busy_o);
    end
    vec_cnt++;
    if (gnt_lane_o !== 2'd2 || gnt_o !== 2'b01) begin
      err_cnt++;
      $display("[TB] FAIL coll_reuse: got lane %0d gnt %b want lane 2 gnt 01", gnt_lane_o, gnt_o);
    end
    tick();
    req_i     = 2'b00;
    release_i = 4'b0001;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b1111 || full_o !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL coll_full: got %b/%b want 1111/1", lane_busy_o, full_o);
    end
    tick();
    release_i = 4'b0000;
    commit_i  = 4'b0001;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b1110 || full_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL coll_release: got %b/%b want 1110/0", lane_busy_o, full_o);
    end
    tick();
    commit_i = 4'b0000;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b1110) begin
      err_cnt++;
      $display("[TB] FAIL commit_on_free: got %b want 1110", lane_busy_o);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    req_i = 2'b01;
    #1;
    vec_cnt++;
    if (gnt_lane_o !== 2'd0 || gnt_valid_o !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL wd_grant: got lane %0d valid %b want 0/1", gnt_lane_o, gnt_valid_o);
    end
    tick();
    req_i = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      #1;
      vec_cnt++;
      if (lane_busy_o !== 4'b0001 || timeout_o !== 4'b0000) begin
        err_cnt++;
        $display("[TB] FAIL wd_hold c%0d: got busy %b to %b want 0001/0000", c, lane_busy_o, timeout_o);
      end
      tick();
    end
    #1;
    vec_cnt++;
    if (timeout_o !== 4'b0001 || lane_busy_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL wd_expire: got to %b busy %b want 0001/0000", timeout_o, lane_busy_o);
    end
    tick();
    #1;
    vec_cnt++;
    if (timeout_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL wd_pulse_len: got %b want 0000", timeout_o);
    end

    // Release lands in the expiry cycle: lane freed without a pulse.
    do_reset();
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    for (int c = 1; c < 8; c++) tick();
    release_i = 4'b0001;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0001) begin
      err_cnt++;
      $display("[TB] FAIL wd_rel_busy: got %b want 0001", lane_busy_o);
    end
    tick();
    release_i = 4'b0000;
    #1;
    vec_cnt++;
    if (timeout_o !== 4'b0000 || lane_busy_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL wd_rel_nopulse: got to %b busy %b want 0000/0000", timeout_o, lane_busy_o);
    end
    tick();
    #1;
    vec_cnt++;
    if (timeout_o !== 4'b0000) begin
      err_cnt++;
      $display("[TB] FAIL wd_rel_late: got %b want 0000", timeout_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_i = 2'b11;
    for (int c = 0; c < 3; c++) tick();
    req_i = 2'b00;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 2'b11;
    #1;
    vec_cnt++;
    if (lane_busy_o !== 4'b0000 || timeout_o !== 4'b0000 || full_o !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL midrst_state: got busy %b to %b full %b want 0000/0000/0", lane_busy_o, timeout_o, full_o);
    end
    vec_cnt++;
    if (gnt_o !== 2'b01 || gnt_lane_o !== 2'd0) begin
      err_cnt++;
      $display("[TB] FAIL midrst_grant: got gnt %b lane %0d want 01/0", gnt_o, gnt_lane_o);
    end
    tick();
    req_i = 2'b00;
    for (int c = 7; c <= 10; c++) begin
      #1;
      vec_cnt++;
      if (timeout_o !== 4'b0000 || lane_busy_o !== 4'b0001) begin
        err_cnt++;
        $display("[TB] FAIL midrst_quiet c%0d: got to %b busy %b want 0000/0001", c, timeout_o, lane_busy_o);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round_robin();
    test_flush();
    test_collision();
    test_watchdog();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/rm_lane_arbiter.md
Name: rm_lane_arbiter

Overview:
Shares the pool of runtime-monitor lanes among several requesters (decode-side event sources) in the ID stage. Arbitration between requesters is round-robin, one grant per cycle. Each grant takes the lowest-indexed free lane. The block then tracks every lane through speculative allocation, commit and release. Flush reclaims speculative lanes, and a per-lane watchdog reclaims lanes that are never released.

Parameters:
NUM_LANES, 4, number of monitor lanes (>=2); LANE_W = $clog2(NUM_LANES) is derived locally.
NUM_REQ, 2, number of requesters (>=1).
TIMEOUT, 1024, cycles a lane may stay allocated before forced reclaim; 0 disables the watchdog.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush; reclaims all speculative lanes
req_i  in  NUM_REQ  per-requester lane request (level)
gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as req
gnt_valid_o  out  1  OR of gnt_o
gnt_lane_o  out  LANE_W  lane index granted this cycle (0 when no grant)
commit_i  in  NUM_LANES  mark lane as committed (non-speculative)
release_i  in  NUM_LANES  lane finished (monitor reset); free lane
lane_busy_o  out  NUM_LANES  lane state != FREE (registered)
timeout_o  out  NUM_LANES  one-cycle registered pulse on watchdog reclaim
full_o  out  1  no lane FREE (registered state)

Behaviour:
- Reset (rst_i=1 at a clock edge): all lanes FREE, all timeout counters 0, RR pointer 0. lane_busy_o=0, timeout_o=0, full_o=0. If rst_i is asserted mid-operation, all allocations are discarded with no timeout pulses.
- Per-lane states: FREE, ALLOC (speculative), COMMITTED.
  - FREE->ALLOC: the lane is granted this cycle.
  - ALLOC->COMMITTED: commit_i[l].
  - ALLOC->FREE: flush_i, or release_i[l], or watchdog.
  - COMMITTED->FREE: release_i[l], or watchdog. flush_i does not affect COMMITTED lanes.
- Priority when events coincide on one lane: release_i > flush_i > watchdog > commit_i.
  - release_i and commit_i together: lane goes FREE.
  - release_i and watchdog expiry together: lane goes FREE with no timeout_o pulse.
- commit_i or release_i on a FREE lane is ignored.
- Grant, combinational:
  - No grant while flush_i=1 or full_o=1.
  - Otherwise the winner is the first requester with req_i set, scanning from the RR pointer upward with wrap.
  - gnt_lane_o is the lowest-indexed FREE lane, based on registered state.
  - A lane freed in cycle t is grantable from cycle t+1; there is no same-cycle bypass.
- RR pointer: on a grant, the pointer becomes (winner+1) mod NUM_REQ; otherwise it holds.
- A requester keeps req_i high until gnt_o[r]. A request dropped without a grant is legal and has no effect.
- Watchdog (TIMEOUT>0):
  - The counter clears on FREE->ALLOC and increments every cycle the lane is not FREE.
  - When the counter reaches TIMEOUT-1 while the lane is still allocated, the lane goes FREE at the next edge and timeout_o[l]=1 for exactly that following cycle.
  - The counter saturates and cannot wrap.
  - With TIMEOUT=0, counters stay 0 and timeout_o stays 0.
- Latency: grant to lane_busy_o[l]=1 is 1 cycle. release_i to lane_busy_o[l]=0 is 1 cycle. full_o is derived from the next-state registers and is therefore valid 1 cycle after the last allocation.
- Multiple lanes may change state in the same cycle (one grant plus any number of releases, commits and timeouts).

Test Plan:
- Reset then fill:
  - Stimulus: NUM_LANES=4, NUM_REQ=2, req_i=2'b01 held for 5 cycles.
  - Required: grants on lanes 0,1,2,3 in cycles 0-3; full_o=1 from cycle 4; no grant in cycle 4.
- Round-robin fairness:
  - Stimulus: req_i=2'b11 for 4 cycles starting from pointer 0.
  - Required: gnt_o=01,10,01,10; gnt_lane_o=0,1,2,3.
- Flush with mixed states:
  - Stimulus: lanes 0-3 allocated, commit_i=4'b0011, next cycle flush_i=1 with req_i=1.
  - Required: gnt_o=0 during flush; next cycle lane_busy_o=4'b0011, full_o=0.
- Release/commit collision and reuse:
  - Stimulus: lane 2 ALLOC, commit_i[2]=release_i[2]=1 in cycle t.
  - Required: lane_busy_o[2]=0 at t+1; a request at t+1 is granted gnt_lane_o=2 if lanes 0,1 are busy.
- Watchdog:
  - Stimulus: TIMEOUT=8; grant lane 0, no release.
  - Required: lane_busy_o[0]=1 for 8 cycles, then timeout_o[0]=1 for one cycle, then lane_busy_o[0]=0.
  - Repeat with release_i[0] in the expiry cycle: no timeout_o pulse.
- Mid-operation reset:
  - Stimulus: 3 lanes busy with counters mid-count, rst_i=1 for one cycle.
  - Required: lane_busy_o=0, timeout_o=0, full_o=0; the next grant goes to lane 0 from requester 0.
